// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b types and helpers for the memory port arbiter
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } mem_arb_state_t;

  localparam lc3b_word STAT_MAX = 16'hFFFF;

  // Width of a port index; a single-port build still carries a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Saturating increment used by the statistics counters.
  function automatic lc3b_word sat_inc(input lc3b_word v);
    return (v == STAT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// rtl/rr_grant.sv - combinational round-robin pick starting after the last granted port
module rr_grant
  import lc3b_types::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int GW        = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] request,
  input  logic [GW-1:0]        last_grant,
  output logic [GW-1:0]        grant,
  output logic                 grant_valid
);

  logic [GW-1:0] cand;

  // Scan last_grant+1 .. last_grant+NUM_PORTS (mod NUM_PORTS); the first requester wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = GW'((int'(last_grant) + k) % NUM_PORTS);
      if (!grant_valid && request[cand]) begin
        grant       = cand;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - N-port round-robin arbiter onto one pmem port (optional stats: MEM_ARB_STATS_EN)
module mem_port_arbiter
  import lc3b_types::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             req_read,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_PORTS*MASK_WIDTH-1:0]  req_mask,
  output logic [DATA_WIDTH-1:0]            req_rdata,
  output logic [NUM_PORTS-1:0]             req_resp,
  output logic                             pmem_read,
  output logic                             pmem_write,
  output logic [ADDR_WIDTH-1:0]            pmem_address,
  output logic [DATA_WIDTH-1:0]            pmem_wdata,
  output logic [MASK_WIDTH-1:0]            pmem_mask,
  input  logic [DATA_WIDTH-1:0]            pmem_rdata,
  input  logic                             pmem_resp
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*16-1:0]          stat_grants,
  output logic [NUM_PORTS*16-1:0]          stat_wait_cycles
`endif
);

  localparam int GW = idx_width(NUM_PORTS);

  mem_arb_state_t       state;
  logic [GW-1:0]        last_grant;
  logic [GW-1:0]        grant;
  logic [GW-1:0]        rr_idx;
  logic                 rr_valid;
  logic                 op_write;
  logic [NUM_PORTS-1:0] request;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_PORTS];
  logic [MASK_WIDTH-1:0] mask_arr  [NUM_PORTS];

  assign request = req_read | req_write;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign addr_arr[i]  = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign mask_arr[i]  = req_mask[i*MASK_WIDTH +: MASK_WIDTH];
  end

  rr_grant #(
    .NUM_PORTS (NUM_PORTS),
    .GW        (GW)
  ) u_rr_grant (
    .request     (request),
    .last_grant  (last_grant),
    .grant       (rr_idx),
    .grant_valid (rr_valid)
  );

  // Transaction FSM: latch the winner in IDLE, hold pmem in BUSY, pulse the requester in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ARB_IDLE;
      last_grant   <= GW'(NUM_PORTS - 1);
      grant        <= '0;
      op_write     <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      pmem_mask    <= '0;
      req_rdata    <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (rr_valid) begin
            grant        <= rr_idx;
            op_write     <= req_write[rr_idx];
            pmem_address <= addr_arr[rr_idx];
            pmem_wdata   <= wdata_arr[rr_idx];
            pmem_mask    <= mask_arr[rr_idx];
            state        <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (pmem_resp) begin
            if (!op_write) begin
              req_rdata <= pmem_rdata;
            end
            last_grant <= grant;
            state      <= ARB_RESP;
          end
        end
        ARB_RESP: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

  // Strobes follow the latched op only while the transaction is in flight.
  assign pmem_read  = (state == ARB_BUSY) && !op_write;
  assign pmem_write = (state == ARB_BUSY) && op_write;

  // One-cycle completion pulse to the port that owns the finished transaction.
  always_comb begin
    req_resp = '0;
    if (state == ARB_RESP) begin
      req_resp[grant] = 1'b1;
    end
  end

  // Flags a requester that presents read and write together when it is granted; the write wins.
  cover property (@(posedge clk) disable iff (!rst_n)
    (state == ARB_IDLE) && rr_valid && req_read[rr_idx] && req_write[rr_idx]);

`ifdef MEM_ARB_STATS_EN
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_stats
    lc3b_word grants_q;
    lc3b_word wait_q;
    logic     granting;
    logic     served;

    assign granting = (state == ARB_IDLE) && rr_valid && (rr_idx == GW'(i));
    assign served   = (state == ARB_IDLE) ? granting : (grant == GW'(i));

    // Count grants and cycles this port spends requesting while another port is served.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        grants_q <= '0;
        wait_q   <= '0;
      end else begin
        if (granting) begin
          grants_q <= sat_inc(grants_q);
        end
        if (request[i] && !served) begin
          wait_q <= sat_inc(wait_q);
        end
      end
    end

    assign stat_grants[i*16 +: 16]      = grants_q;
    assign stat_wait_cycles[i*16 +: 16] = wait_q;
  end
`endif

endmodule
